// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolve unit: branch opcodes, next-PC selects,
// FSM states and the status-flag payload.
package branch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] BR_NONE   = 4'd0;
  localparam logic [OP_W-1:0] BR_BEQ    = 4'd1;
  localparam logic [OP_W-1:0] BR_BNE    = 4'd2;
  localparam logic [OP_W-1:0] BR_BZ     = 4'd3;
  localparam logic [OP_W-1:0] BR_BN     = 4'd4;
  localparam logic [OP_W-1:0] BR_BV     = 4'd5;
  localparam logic [OP_W-1:0] BR_BRV    = 4'd6;
  localparam logic [OP_W-1:0] BR_BLEZAL = 4'd7;
  localparam logic [OP_W-1:0] BR_JM     = 4'd8;
  localparam logic [OP_W-1:0] BR_JML    = 4'd9;

  localparam logic [SEL_W-1:0] PCSEL_SEQ = 2'd0;
  localparam logic [SEL_W-1:0] PCSEL_BR  = 2'd1;
  localparam logic [SEL_W-1:0] PCSEL_REG = 2'd2;
  localparam logic [SEL_W-1:0] PCSEL_JM  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_RESOLVE  = 2'd2,
    S_ABORT    = 2'd3
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } status_t;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Zero-latency branch decode: next-PC select, link request and memory-indirect
// detection from the opcode, the ALU zero output and the registered flags.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [OP_W-1:0]  br_op,
  input  logic             alu_zout,
  input  status_t          status,
  output logic [SEL_W-1:0] pc_sel_c,
  output logic             link_c,
  output logic             jm_c
);

  always_comb begin
    pc_sel_c = PCSEL_SEQ;
    link_c   = 1'b0;
    jm_c     = 1'b0;
    case (br_op)
      BR_BEQ:    if (alu_zout)        pc_sel_c = PCSEL_BR;
      BR_BNE:    if (!alu_zout)       pc_sel_c = PCSEL_BR;
      BR_BZ:     if (status.z)        pc_sel_c = PCSEL_BR;
      BR_BN:     if (status.n)        pc_sel_c = PCSEL_BR;
      BR_BV:     if (status.v)        pc_sel_c = PCSEL_BR;
      BR_BRV:    pc_sel_c = PCSEL_REG;
      BR_BLEZAL: if (status.n || status.z) begin
        pc_sel_c = PCSEL_BR;
        link_c   = 1'b1;
      end
      BR_JM, BR_JML: jm_c = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution: status flag register, branch/jump next-PC selection and the
// memory-indirect jump FSM with request/ack handshake and timeout.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  br_op,
  input  logic             flag_we,
  input  logic [XLEN-1:0]  alu_sum,
  input  logic             alu_zout,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  br_target,
  input  logic             mem_ack,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic [SEL_W-1:0] pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic             stall,
  output logic             link_we,
  output logic             mem_req,
  output logic [XLEN-1:0]  mem_addr,
  output logic             status_n,
  output logic             status_z,
  output logic             status_v,
  output logic             jm_err
);

  state_t           state, state_nx;
  status_t          status_q;
  logic [XLEN-1:0]  jreg_q;
  logic [XLEN-1:0]  addr_q;
  logic             jml_q;
  logic [CNT_W-1:0] cnt_q;
  logic             jm_err_q;
  logic             cnt_last;
  logic [SEL_W-1:0] dec_sel;
  logic             dec_link;
  logic             dec_jm;

  branch_cond_eval u_cond (
    .br_op    (br_op),
    .alu_zout (alu_zout),
    .status   (status_q),
    .pc_sel_c (dec_sel),
    .link_c   (dec_link),
    .jm_c     (dec_jm)
  );

  // The count reaches TIMEOUT-1 on this cycle's increment.
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 2));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (dec_jm) state_nx = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (mem_ack)       state_nx = S_RESOLVE;
        else if (cnt_last) state_nx = S_ABORT;
      end
      S_RESOLVE:  state_nx = S_IDLE;
      S_ABORT:    state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pc_sel   = PCSEL_SEQ;
    stall    = 1'b0;
    link_we  = 1'b0;
    mem_req  = 1'b0;
    mem_addr = addr_q;
    case (state)
      S_IDLE: begin
        if (dec_jm) begin
          mem_req  = 1'b1;
          mem_addr = alu_sum;
          stall    = 1'b1;
        end else begin
          pc_sel  = dec_sel;
          link_we = dec_link;
        end
      end
      S_MEM_WAIT: begin
        mem_req = 1'b1;
        stall   = 1'b1;
      end
      S_RESOLVE: begin
        pc_sel  = PCSEL_JM;
        link_we = jml_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (pc_sel)
      PCSEL_BR:  pc_target = br_target;
      PCSEL_REG: pc_target = alu_sum;
      PCSEL_JM:  pc_target = jreg_q;
      default:   pc_target = pc_plus4;
    endcase
  end

  // Flags, captured jump request, jump register, timeout counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
      jreg_q   <= '0;
      addr_q   <= '0;
      jml_q    <= 1'b0;
      cnt_q    <= '0;
      jm_err_q <= 1'b0;
    end else begin
      if (flag_we && !stall) status_q <= '{n: alu_n, z: alu_z, v: alu_v};
      if (state == S_IDLE && dec_jm) begin
        addr_q <= alu_sum;
        jml_q  <= (br_op == BR_JML);
        cnt_q  <= '0;
      end
      if (state == S_MEM_WAIT) begin
        if (mem_ack) begin
          jreg_q <= mem_rdata;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_last) jm_err_q <= 1'b1;
        end
      end
    end
  end

  assign status_n = status_q.n;
  assign status_z = status_q.z;
  assign status_v = status_q.v;
  assign jm_err   = jm_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: expected next-PC/handshake outputs are
// queued as each cycle's stimulus is driven and compared once the outputs settle.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam logic [31:0] PC4 = 32'h0000_1004;
  localparam logic [31:0] BRT = 32'h0000_2000;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic        stall;
    logic        link;
    logic        req;
    logic [31:0] addr;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  br_op;
  logic        flag_we, alu_zout, alu_n, alu_z, alu_v, mem_ack;
  logic [31:0] alu_sum, pc_plus4, br_target, mem_rdata;
  logic [1:0]  pc_sel;
  logic [31:0] pc_target, mem_addr;
  logic        stall, link_we, mem_req, status_n, status_z, status_v, jm_err;

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t sb[$];
  obs_t got, e;

  branch_resolve_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .br_op(br_op), .flag_we(flag_we), .alu_sum(alu_sum),
    .alu_zout(alu_zout), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .pc_plus4(pc_plus4), .br_target(br_target), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc_sel(pc_sel), .pc_target(pc_target), .stall(stall), .link_we(link_we),
    .mem_req(mem_req), .mem_addr(mem_addr), .status_n(status_n), .status_z(status_z),
    .status_v(status_v), .jm_err(jm_err)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [1:0] sel, input logic [31:0] tgt, input logic st,
                              input logic lk, input logic rq, input logic [31:0] ad);
    obs_t o;
    o.sel = sel; o.tgt = tgt; o.stall = st; o.link = lk; o.req = rq; o.addr = ad;
    return o;
  endfunction

  // mem_addr only carries meaning while a request is up.
  function automatic obs_t observe();
    obs_t o;
    o.sel = pc_sel; o.tgt = pc_target; o.stall = stall; o.link = link_we; o.req = mem_req;
    o.addr = mem_req ? mem_addr : 32'h0;
    return o;
  endfunction

  task automatic drive(input logic [3:0] op, input logic fwe, input logic n, input logic z,
                       input logic v, input logic zout, input logic [31:0] sum,
                       input logic ack, input logic [31:0] rdata);
    @(negedge clk);
    br_op = op; flag_we = fwe; alu_n = n; alu_z = z; alu_v = v; alu_zout = zout;
    alu_sum = sum; mem_ack = ack; mem_rdata = rdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    br_op = BR_NONE; flag_we = 1'b0; alu_n = 1'b0; alu_z = 1'b0; alu_v = 1'b0;
    alu_zout = 1'b0; alu_sum = '0; mem_ack = 1'b0; mem_rdata = '0;
    pc_plus4 = PC4; br_target = BRT;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.push_back(mk(PCSEL_SEQ, PC4, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL reset_outputs: got %h want %h", got, e); end
    n_cmp++;
    if ({status_n, status_z, status_v, jm_err} !== 4'b0000) begin
      n_err++; $display("FAIL reset_regs: got %b want 0000", {status_n, status_z, status_v, jm_err});
    end
  endtask

  task automatic test_status_bz();
    drive(BR_NONE, 1, 0, 1, 0, 0, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_SEQ, PC4, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL bz_setup: got %h want %h", got, e); end
    drive(BR_BZ, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_BR, BRT, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL bz_taken: got %h want %h", got, e); end
    n_cmp++;
    if (status_z !== 1'b1) begin n_err++; $display("FAIL status_z: got %b want 1", status_z); end
  endtask

  task automatic test_cond_ops();
    // Same-cycle flag write must not affect BN; the following BN sees it.
    drive(BR_BN, 1, 1, 0, 0, 0, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_SEQ, PC4, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL bn_same_cycle: got %h want %h", got, e); end
    drive(BR_BN, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_BR, BRT, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL bn_next: got %h want %h", got, e); end
    // Flags now n=1 z=0 v=0.
    drive(BR_BEQ, 0, 0, 0, 0, 1, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_BR, BRT, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL beq_taken: got %h want %h", got, e); end
    drive(BR_BNE, 0, 0, 0, 0, 1, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_SEQ, PC4, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL bne_not_taken: got %h want %h", got, e); end
    drive(BR_BV, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_SEQ, PC4, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL bv_not_taken: got %h want %h", got, e); end
    drive(BR_BRV, 0, 0, 0, 0, 0, 32'h0000_3000, 0, 0);
    sb.push_back(mk(PCSEL_REG, 32'h0000_3000, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL brv: got %h want %h", got, e); end
    drive(4'd12, 0, 0, 0, 0, 1, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_SEQ, PC4, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL op_reserved: got %h want %h", got, e); end
  endtask

  task automatic test_blezal();
    drive(BR_NONE, 1, 0, 1, 0, 0, 32'h0, 0, 0);
    drive(BR_BLEZAL, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_BR, BRT, 0, 1, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL blezal_taken: got %h want %h", got, e); end
    drive(BR_NONE, 1, 0, 0, 0, 0, 32'h0, 0, 0);
    drive(BR_BLEZAL, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_SEQ, PC4, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL blezal_not_taken: got %h want %h", got, e); end
  endtask

  task automatic test_jml();
    drive(BR_JML, 0, 0, 0, 0, 0, 32'h0000_0100, 0, 0);
    sb.push_back(mk(PCSEL_SEQ, PC4, 1, 0, 1, 32'h100));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL jml_issue: got %h want %h", got, e); end
    // Opcode, address and flag writes while stalled are ignored.
    for (int i = 2; i <= 4; i++) begin
      drive(BR_BRV, 1, 1, 1, 1, 0, 32'h0000_dead, (i == 4), 32'h0040_0020);
      sb.push_back(mk(PCSEL_SEQ, PC4, 1, 0, 1, 32'h100));
      #1; got = observe(); e = sb.pop_front(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL jml_wait%0d: got %h want %h", i, got, e); end
    end
    drive(BR_NONE, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_JM, 32'h0040_0020, 0, 1, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL jml_resolve: got %h want %h", got, e); end
    n_cmp++;
    if ({status_n, status_z, status_v} !== 3'b000) begin
      n_err++; $display("FAIL flags_held_in_stall: got %b want 000", {status_n, status_z, status_v});
    end
    drive(BR_NONE, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_SEQ, PC4, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL jml_back_idle: got %h want %h", got, e); end
  endtask

  task automatic test_jm_ack_last();
    for (int i = 1; i <= 16; i++) begin
      drive((i == 1) ? BR_JM : BR_NONE, 0, 0, 0, 0, 0, (i == 1) ? 32'h300 : 32'h0,
            (i == 16), 32'h1234_5678);
      sb.push_back(mk(PCSEL_SEQ, PC4, 1, 0, 1, 32'h300));
      #1; got = observe(); e = sb.pop_front(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL ack_last_wait%0d: got %h want %h", i, got, e); end
    end
    drive(BR_NONE, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_JM, 32'h1234_5678, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL ack_last_resolve: got %h want %h", got, e); end
    n_cmp++;
    if (jm_err !== 1'b0) begin n_err++; $display("FAIL ack_last_err: got %b want 0", jm_err); end
  endtask

  task automatic test_jm_timeout();
    for (int i = 1; i <= 16; i++) begin
      drive((i == 1) ? BR_JM : BR_NONE, 0, 0, 0, 0, 0, (i == 1) ? 32'h200 : 32'h0, 0, 0);
      sb.push_back(mk(PCSEL_SEQ, PC4, 1, 0, 1, 32'h200));
      #1; got = observe(); e = sb.pop_front(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL timeout_wait%0d: got %h want %h", i, got, e); end
    end
    drive(BR_NONE, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_SEQ, PC4, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL timeout_abort: got %h want %h", got, e); end
    n_cmp++;
    if (jm_err !== 1'b1) begin n_err++; $display("FAIL timeout_err: got %b want 1", jm_err); end
    repeat (3) drive(BR_BEQ, 0, 0, 0, 0, 1, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_BR, BRT, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL after_abort: got %h want %h", got, e); end
    n_cmp++;
    if (jm_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", jm_err); end
  endtask

  task automatic test_reset_midwait();
    drive(BR_NONE, 1, 1, 1, 1, 0, 32'h0, 0, 0);
    drive(BR_JML, 0, 0, 0, 0, 0, 32'h400, 0, 0);
    drive(BR_NONE, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    sb.push_back(mk(PCSEL_SEQ, PC4, 1, 0, 1, 32'h400));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL midwait_wait: got %h want %h", got, e); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(mk(PCSEL_SEQ, PC4, 0, 0, 0, 0));
    #1; got = observe(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL midwait_reset: got %h want %h", got, e); end
    n_cmp++;
    if ({status_n, status_z, status_v, jm_err} !== 4'b0000) begin
      n_err++; $display("FAIL midwait_regs: got %b want 0000", {status_n, status_z, status_v, jm_err});
    end
  endtask

  initial begin
    test_reset();
    test_status_bz();
    test_cond_ops();
    test_blezal();
    test_jml();
    test_jm_ack_last();
    test_jm_timeout();
    test_reset_midwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
